reg_dump: RTL and testbench
===========================

REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 The block SHALL have exactly one clock and reset; reset is asynchronous and active-low.
REQ-002 Parameter NUM_REGS, default 16, number of register indices the block may read (0..NUM_REGS-1).
REQ-003 Parameter SETTLE, default 1, number of clk cycles `which_reg` is held before `reg_content` is sampled (range 1..7).
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-007 first_reg  in  5  first register index of the dump, sampled with start.
REQ-008 last_reg  in  5  last register index of the dump, sampled with start.
REQ-009 abort  in  1  terminate the dump in progress.
REQ-010 which_reg  out  5  register-file debug read select.
REQ-011 reg_content  in  32  register-file debug read data for `which_reg`.
REQ-012 out_valid  out  1  out_data/out_idx/out_last hold a word.
REQ-013 out_ready  in  1  consumer accepts the word when out_valid && out_ready.
REQ-014 out_data  out  32  captured register value.
REQ-015 out_idx  out  5  register index of out_data.
REQ-016 out_last  out  1  word is the final word of the dump.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse after the last word is accepted.

Function
REQ-019 FSM states SHALL be IDLE, SELECT, CAPTURE, HOLD, DONE.
REQ-020 IDLE -> SELECT on start; latch first_reg as current index, last_reg as end index.
REQ-021 Any latched index >= NUM_REGS SHALL be replaced by NUM_REGS-1.
REQ-022 SELECT: which_reg = current index; a settle counter runs SETTLE cycles, then -> CAPTURE.
REQ-023 CAPTURE: out_data <= reg_content, out_idx <= current index, out_last <= (current == end); -> HOLD with out_valid = 1 the next cycle.
REQ-024 HOLD: out_data, out_idx, out_last SHALL stay stable while out_valid && !out_ready.
REQ-025 HOLD on acceptance: if out_last, -> DONE; else current index increments, wrapping NUM_REGS-1 -> 0, and -> SELECT.
REQ-026 A dump with first_reg > last_reg SHALL wrap: first..NUM_REGS-1, then 0..last.
REQ-027 A dump with first_reg == last_reg SHALL produce exactly one word with out_last = 1.
REQ-028 DONE: done = 1 for exactly one cycle, -> IDLE.
REQ-029 out_valid SHALL fall in the cycle after acceptance; there is no back-to-back streaming. The minimum per-word period is SETTLE + 2 cycles.
REQ-030 start while busy SHALL be ignored.
REQ-031 abort in any non-IDLE state SHALL force IDLE on the next edge, with out_valid = 0 and no done pulse. Abort takes priority over acceptance in the same cycle.
REQ-032 which_reg SHALL hold its last value in IDLE, HOLD and DONE.

Reset
REQ-033 While rst = 0: state IDLE, which_reg = 0, out_valid = 0, out_data = 0, out_idx = 0, out_last = 0, busy = 0, done = 0, counters = 0.
REQ-034 Reset assertion mid-dump SHALL discard the dump immediately, asynchronously.
REQ-035 After rst deasserts, the first start is honoured on the first rising edge.

Structure
REQ-036 The FSM state encoding and the default values of NUM_REGS and SETTLE SHALL live in the shared CPU package.
REQ-037 The block SHALL be a single module; the settle counter stays inline, with no sub-module.

Verification
REQ-038 Verification SHALL cover the following directed scenarios:
- Regs r1..r15 preloaded with 0x100+i; start, first=0, last=15, out_ready=1 -> 16 words, idx 0..15, data 0 then 0x101..0x10F, out_last only on idx 15, one done pulse.
- first=14, last=1 -> idx sequence 14, 15, 0, 1; out_last on idx 1.
- first=5, last=5, out_ready held 0 for 10 cycles -> out_data = 0x105 stable for all 10 cycles; single word; done one cycle after acceptance.
- abort asserted while in HOLD at idx 3 -> out_valid = 0 next cycle, busy = 0, no done; a new start is accepted afterwards.
- start repeated while busy, and first=20/last=31 -> extra start ignored; out-of-range indices clamp so the dump emits a single idx 15 word.
- rst pulled low mid-SELECT -> all outputs zero asynchronously; a dump after release completes normally.

Source files
------------

// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register-dump engine: FSM encoding,
// default geometry and index helpers.
package reg_dump_pkg;

    localparam int NUM_REGS_DEFAULT = 16;
    localparam int SETTLE_DEFAULT   = 1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SELECT  = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_HOLD    = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    // Indices beyond the implemented register file collapse onto the top register.
    function automatic logic [4:0] clamp_idx(input logic [4:0] idx, input logic [4:0] max_idx);
        if (idx > max_idx) begin
            return max_idx;
        end else begin
            return idx;
        end
    endfunction

    // Advance an index, wrapping from the top register back to register 0.
    function automatic logic [4:0] next_idx(input logic [4:0] idx, input logic [4:0] max_idx);
        if (idx == max_idx) begin
            return 5'd0;
        end else begin
            return idx + 5'd1;
        end
    endfunction

endpackage

// File: rtl/reg_dump.sv
// Register-file dump engine: walks a (possibly wrapping) index range,
// holds each select for SETTLE cycles, captures the read data and
// presents it one word at a time on a valid/ready output.
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEFAULT,
    parameter int SETTLE   = SETTLE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  first_reg,
    input  logic [4:0]  last_reg,
    input  logic        abort,
    output logic [4:0]  which_reg,
    input  logic [31:0] reg_content,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_idx,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] MAX_IDX     = 5'(NUM_REGS - 1);
    localparam logic [2:0] SETTLE_LAST = 3'(SETTLE - 1);

    logic [2:0] state_r;
    logic [2:0] st_nx_s;
    logic [2:0] cnt_r;
    logic [4:0] cur_r;
    logic [4:0] end_r;
    logic [4:0] first_c_s;
    logic [4:0] last_c_s;
    logic [4:0] inc_s;
    logic       accept_s;

    assign first_c_s = clamp_idx(first_reg, MAX_IDX);
    assign last_c_s  = clamp_idx(last_reg, MAX_IDX);
    assign inc_s     = next_idx(cur_r, MAX_IDX);
    assign accept_s  = out_valid && out_ready;

    // Next-state selection; abort overrides every other transition out of a busy state.
    always_comb begin
        st_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    st_nx_s = ST_SELECT;
                end else begin
                    st_nx_s = ST_IDLE;
                end
            end
            ST_SELECT: begin
                if (cnt_r == SETTLE_LAST) begin
                    st_nx_s = ST_CAPTURE;
                end else begin
                    st_nx_s = ST_SELECT;
                end
            end
            ST_CAPTURE: begin
                st_nx_s = ST_HOLD;
            end
            ST_HOLD: begin
                if (accept_s) begin
                    if (out_last) begin
                        st_nx_s = ST_DONE;
                    end else begin
                        st_nx_s = ST_SELECT;
                    end
                end else begin
                    st_nx_s = ST_HOLD;
                end
            end
            ST_DONE: begin
                st_nx_s = ST_IDLE;
            end
            default: begin
                st_nx_s = ST_IDLE;
            end
        endcase
        if (abort && (state_r != ST_IDLE)) begin
            st_nx_s = ST_IDLE;
        end else begin
            st_nx_s = st_nx_s;
        end
    end

    // State register and status flags, all registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 3'd0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_r   <= st_nx_s;
            busy      <= (st_nx_s != ST_IDLE);
            out_valid <= (st_nx_s == ST_HOLD);
            done      <= (st_nx_s == ST_DONE);
            if ((state_r == ST_SELECT) && (st_nx_s == ST_SELECT)) begin
                cnt_r <= cnt_r + 3'd1;
            end else begin
                cnt_r <= 3'd0;
            end
        end
    end

    // Index tracking, read select and output word capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_r     <= 5'd0;
            end_r     <= 5'd0;
            which_reg <= 5'd0;
            out_data  <= 32'd0;
            out_idx   <= 5'd0;
            out_last  <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) && (st_nx_s == ST_SELECT)) begin
                cur_r     <= first_c_s;
                end_r     <= last_c_s;
                which_reg <= first_c_s;
            end else if ((state_r == ST_HOLD) && (st_nx_s == ST_SELECT)) begin
                cur_r     <= inc_s;
                which_reg <= inc_s;
            end
            if ((state_r == ST_CAPTURE) && (st_nx_s == ST_HOLD)) begin
                out_data <= reg_content;
                out_idx  <= cur_r;
                out_last <= (cur_r == end_r);
            end
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump: a queue of expected words derived from the
// requested range is checked against the output every cycle.
module tb_reg_dump;
    import reg_dump_pkg::*;

    localparam int N = 16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  first_reg;
    logic [4:0]  last_reg;
    logic        abort;
    logic [4:0]  which_reg;
    logic [31:0] reg_content;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] regfile [32];

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
    } word_t;

    word_t exp_q [$];
    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int acc_cnt = 0;
    bit after_last = 1'b0;
    bit after_acc = 1'b0;
    bit after_abort = 1'b0;

    reg_dump dut (
        .clk(clk), .rst(rst), .start(start), .first_reg(first_reg),
        .last_reg(last_reg), .abort(abort), .which_reg(which_reg),
        .reg_content(reg_content), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb reg_content = regfile[which_reg];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected words of a dump: clamp both ends, walk forward with wrap.
    task automatic build(input int f, input int l);
        int i;
        int fc;
        int lc;
        fc = (f >= N) ? N - 1 : f;
        lc = (l >= N) ? N - 1 : l;
        exp_q.delete();
        i = fc;
        forever begin
            exp_q.push_back('{idx: 5'(i), data: regfile[i], last: (i == lc)});
            if (i == lc) break;
            i = (i + 1) % N;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [4:0] f, input logic [4:0] l);
        first_reg = f;
        last_reg  = l;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        d0 = done_cnt;
        for (int k = 0; k < budget; k++) begin
            if (done_cnt != d0) break;
            tick();
        end
        chk(name, done_cnt - d0, 32'd1);
        tick();
        chk("idle_after_done", {31'd0, busy}, 32'd0);
        chk("queue_drained", exp_q.size(), 32'd0);
    endtask

    // Per-cycle comparison of the output stream against the expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            after_last  = 1'b0;
            after_acc   = 1'b0;
            after_abort = 1'b0;
        end else begin
            chk("done_timing", {31'd0, done}, {31'd0, after_last});
            if (done) done_cnt++;
            if (after_acc || after_abort) chk("valid_drop", {31'd0, out_valid}, 32'd0);
            if (after_abort) chk("abort_busy", {31'd0, busy}, 32'd0);
            after_last  = 1'b0;
            after_acc   = 1'b0;
            after_abort = 1'b0;
            if (abort && busy) begin
                exp_q.delete();
                after_abort = 1'b1;
            end else if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {31'd0, out_valid}, 32'd0);
                end else begin
                    chk("word_idx", {27'd0, out_idx}, {27'd0, exp_q[0].idx});
                    chk("word_data", out_data, exp_q[0].data);
                    chk("word_last", {31'd0, out_last}, {31'd0, exp_q[0].last});
                    if (out_ready) begin
                        after_acc  = 1'b1;
                        after_last = exp_q[0].last;
                        exp_q.pop_front();
                        acc_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0;
        int d0;
        for (int i = 0; i < 32; i++) regfile[i] = (i == 0) ? 32'd0 : 32'h100 + 32'(i);
        start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        first_reg = 5'd0; last_reg = 5'd0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("rst_which_reg", {27'd0, which_reg}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_idx", {27'd0, out_idx}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        tick();

        // Full dump 0..15 with start on the first edge after release.
        build(0, 15);
        chk("model_full_size", exp_q.size(), 32'd16);
        chk("model_full_d0", exp_q[0].data, 32'h0);
        chk("model_full_d1", exp_q[1].data, 32'h101);
        chk("model_full_last", {31'd0, exp_q[15].last}, 32'd1);
        out_ready = 1'b1;
        rst = 1'b1;
        a0 = acc_cnt;
        pulse_start(5'd0, 5'd15);
        wait_done("full_done", 200);
        chk("full_words", acc_cnt - a0, 32'd16);
        chk("idle_which_reg", {27'd0, which_reg}, 32'd15);

        // Wrapping dump 14..1.
        build(14, 1);
        chk("model_wrap_size", exp_q.size(), 32'd4);
        chk("model_wrap_idx2", {27'd0, exp_q[2].idx}, 32'd0);
        a0 = acc_cnt;
        pulse_start(5'd14, 5'd1);
        wait_done("wrap_done", 100);
        chk("wrap_words", acc_cnt - a0, 32'd4);
        chk("wrap_which_reg", {27'd0, which_reg}, 32'd1);

        // Single word with a stalled consumer.
        build(5, 5);
        out_ready = 1'b0;
        a0 = acc_cnt;
        pulse_start(5'd5, 5'd5);
        for (int k = 0; k < 20 && !out_valid; k++) tick();
        chk("stall_valid_seen", {31'd0, out_valid}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            chk("stall_data", out_data, 32'h105);
            chk("stall_last", {31'd0, out_last}, 32'd1);
            tick();
        end
        out_ready = 1'b1;
        wait_done("stall_done", 20);
        chk("stall_words", acc_cnt - a0, 32'd1);

        // Abort while holding idx 3, with ready raised in the same cycle.
        build(0, 7);
        out_ready = 1'b0;
        pulse_start(5'd0, 5'd7);
        for (int k = 0; k < 100; k++) begin
            if (out_valid && out_idx == 5'd3) break;
            out_ready = out_valid;
            tick();
        end
        chk("abort_at_idx3", {31'd0, out_valid && out_idx == 5'd3}, 32'd1);
        d0 = done_cnt;
        abort = 1'b1;
        out_ready = 1'b1;
        tick();
        abort = 1'b0;
        out_ready = 1'b0;
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_busy_now", {31'd0, busy}, 32'd0);
        repeat (5) tick();
        chk("abort_no_done", done_cnt - d0, 32'd0);
        build(2, 2);
        out_ready = 1'b1;
        pulse_start(5'd2, 5'd2);
        wait_done("post_abort_done", 20);

        // Out-of-range request plus a second start while busy.
        build(20, 31);
        chk("model_clamp_size", exp_q.size(), 32'd1);
        chk("model_clamp_idx", {27'd0, exp_q[0].idx}, 32'd15);
        a0 = acc_cnt;
        pulse_start(5'd20, 5'd31);
        first_reg = 5'd0; last_reg = 5'd3; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("clamp_done", 20);
        repeat (6) tick();
        chk("clamp_words", acc_cnt - a0, 32'd1);
        chk("clamp_still_idle", {31'd0, busy}, 32'd0);

        // Reset in the middle of SELECT, then a normal dump.
        build(0, 15);
        pulse_start(5'd0, 5'd15);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_which_reg", {27'd0, which_reg}, 32'd0);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_out_data", out_data, 32'd0);
        chk("mid_rst_out_idx", {27'd0, out_idx}, 32'd0);
        chk("mid_rst_out_last", {31'd0, out_last}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        tick();
        rst = 1'b1;
        build(3, 6);
        a0 = acc_cnt;
        pulse_start(5'd3, 5'd6);
        wait_done("post_rst_done", 60);
        chk("post_rst_words", acc_cnt - a0, 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
